fft_stage_buffer: RTL

- Iteration controller and working register bank for the 32-point in-place DIT FFT.
- Accepts one 32-point complex frame and drives the stage datapath (butterfly array followed by the output routing network) from its register bank.
- Captures the routed result back into the bank once per stage while stepping the stage selector SB through 0..4, then presents the finished frame with a valid/ready handshake.
- Sits directly downstream of the output routing network; its register outputs close the feedback loop to the butterfly array.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_stage_buffer_if.sv | 37 +++
 rtl/fft_stage_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point in-place FFT stage controller:
// FSM state encoding and frame/stage geometry.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          N_POINTS = 32;
    localparam int          N_STAGES = 5;
    localparam logic [2:0]  SB_LAST  = 3'(N_STAGES - 1);

endpackage

// File: rtl/fft_stage_buffer_if.sv
// Bundle of frame handshake, datapath feedback and stage-select signals
// between the FFT stage buffer and its surroundings.
interface fft_stage_buffer_if #(
    parameter int WIDTH = 16
) ();

    localparam int BUS_W = WIDTH * fft_pkg::N_POINTS;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] Real_in;
    logic [BUS_W-1:0] imag_in;
    logic [BUS_W-1:0] route_real;
    logic [BUS_W-1:0] route_imag;
    logic [BUS_W-1:0] stage_real;
    logic [BUS_W-1:0] stage_imag;
    logic [2:0]       SB;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] Real_out;
    logic [BUS_W-1:0] imag_out;
    logic             busy;

    // Environment side: frame source, frame sink and the stage datapath.
    modport master (
        output flush, in_valid, Real_in, imag_in, route_real, route_imag, out_ready,
        input  in_ready, stage_real, stage_imag, SB, out_valid, Real_out, imag_out, busy
    );

    // Controller side.
    modport slave (
        input  flush, in_valid, Real_in, imag_in, route_real, route_imag, out_ready,
        output in_ready, stage_real, stage_imag, SB, out_valid, Real_out, imag_out, busy
    );

endinterface

// File: rtl/fft_stage_buffer.sv
// Iteration controller and working register bank for the 32-point in-place
// DIT FFT: loads a frame, runs five stage captures, then offers the result.
module fft_stage_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    fft_stage_buffer_if.slave  bus
);

    localparam int BUS_W = WIDTH * N_POINTS;

    state_e           state_q,     state_d;
    logic [2:0]       sb_q,        sb_d;
    logic [BUS_W-1:0] bank_re_q,   bank_re_d;
    logic [BUS_W-1:0] bank_im_q,   bank_im_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic             in_ready_q,  in_ready_d;

    always_comb begin
        // NOTE: every _d gets a hold value first so no path through the case leaves it unassigned (no latch).
        state_d     = state_q;
        sb_d        = sb_q;
        bank_re_d   = bank_re_q;
        bank_im_d   = bank_im_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    bank_re_d  = bus.Real_in;
                    bank_im_d  = bus.imag_in;
                    sb_d       = 3'd0;
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                // The butterfly/routing path is combinational: one stage retires per cycle.
                bank_re_d = bus.route_real;
                bank_im_d = bus.route_imag;
                if (sb_q == SB_LAST) begin
                    sb_d        = 3'd0;
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    sb_d = sb_q + 3'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                sb_d        = 3'd0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // Abort wins over any transition above; the bank keeps its last contents.
        if (bus.flush) begin
            state_d     = IDLE;
            sb_d        = 3'd0;
            bank_re_d   = bank_re_q;
            bank_im_d   = bank_im_q;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RST) begin
            state_q     <= IDLE;
            sb_q        <= 3'd0;
            // NOTE: the bank is cleared on reset because its value is visible on stage_* and *_out.
            bank_re_q   <= '0;
            bank_im_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sb_q        <= sb_d;
            bank_re_q   <= bank_re_d;
            bank_im_q   <= bank_im_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // in_ready is held low for as long as reset is asserted, not just after the first edge.
    assign bus.in_ready   = in_ready_q & RST;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.SB         = sb_q;
    assign bus.stage_real = bank_re_q;
    assign bus.stage_imag = bank_im_q;
    assign bus.Real_out   = bank_re_q;
    assign bus.imag_out   = bank_im_q;

endmodule
